as_gpio_ctrl: RTL

//  Parametrised memory-mapped GPIO controller for the rv64i SoC; successor of the fixed 8-pin GPIO.

---
 rtl/as_gpio_ctrl_pkg.sv | 24 ++
 rtl/as_gpio_ctrl_if.sv | 31 +++
 rtl/as_gpio_ctrl_sync.sv | 35 +++
 rtl/as_gpio_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/as_gpio_ctrl_pkg.sv
// Package: as_gpio_ctrl_pkg
// Purpose: shared definitions for the GPIO controller -- register word
//          indices and the default identification value returned by ID.
// Contents:
//   gpio_reg_e       register word index map (ID .. FALL)
//   GPIO_ID_DEFAULT  value software reads from the ID register
package as_gpio_ctrl_pkg;

    typedef enum logic [3:0] {
        GPIO_ID_R     = 4'd0,   // read-only block identifier
        GPIO_DIR_R    = 4'd1,   // per-pin direction, 1 = drive
        GPIO_OUT_R    = 4'd2,   // output data
        GPIO_IN_R     = 4'd3,   // synchronised pad state, read-only
        GPIO_SET_R    = 4'd4,   // write-only, OUT |= wdata
        GPIO_CLR_R    = 4'd5,   // write-only, OUT &= ~wdata
        GPIO_IRQ_EN_R = 4'd6,   // interrupt enable mask
        GPIO_STAT_R   = 4'd7,   // sticky edge status, write-1-to-clear
        GPIO_RISE_R   = 4'd8,   // rising-edge detect enable
        GPIO_FALL_R   = 4'd9    // falling-edge detect enable
    } gpio_reg_e;

    localparam logic [63:0] GPIO_ID_DEFAULT = 64'h0000_0000_0000_0081;

endpackage

// File: rtl/as_gpio_ctrl_if.sv
// Interface: as_gpio_ctrl_if
// Purpose: core data-bus slave port of the GPIO controller.
// Signals:
//   addr_i   register word index
//   we_i     single-cycle write strobe
//   re_i     single-cycle read strobe
//   wdata_i  write data
//   rdata_o  registered read data, zero-extended
//   rvalid_o read data valid, one cycle after re_i
// Modports: master (bus initiator), slave (GPIO controller).
interface as_gpio_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4
) ();
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  we_i;
    logic                  re_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  rvalid_o;

    modport master (
        output addr_i, we_i, re_i, wdata_i,
        input  rdata_o, rvalid_o
    );

    modport slave (
        input  addr_i, we_i, re_i, wdata_i,
        output rdata_o, rvalid_o
    );
endinterface

// File: rtl/as_gpio_ctrl_sync.sv
// Module: as_gpio_ctrl_sync
// Purpose: multi-flop synchroniser bringing asynchronous pad inputs into
//          the clk_i domain; every stage clears on synchronous reset.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   i_async  asynchronous pad inputs
//   o_sync   synchronised copy, SYNC_STAGES edges behind i_async
module as_gpio_ctrl_sync #(
    parameter int NR_GPIOS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NR_GPIOS-1:0] i_async,
    output logic [NR_GPIOS-1:0] o_sync
);

    logic [SYNC_STAGES-1:0][NR_GPIOS-1:0] r_chain;

    // Shift the pad sample through the flop chain, stage 0 first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_chain[s] <= r_chain[s-1];
            end
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/as_gpio_ctrl.sv
// Module: as_gpio_ctrl
// Purpose: memory-mapped GPIO controller with per-pin direction, atomic
//          SET/CLR, synchronised inputs and rise/fall edge interrupts.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   bus        data-bus slave (addr/we/re/wdata in, rdata/rvalid out)
//   gpio_i     asynchronous pad inputs
//   gpio_o     output data to pad logic
//   gpio_oe_o  output enable, 1 = drive
//   cs_o       one-cycle pulse after a write to OUT, SET or CLR
//   irq_o      level interrupt, |(STAT & IRQ_EN) delayed one cycle
module as_gpio_ctrl
    import as_gpio_ctrl_pkg::*;
#(
    parameter int                    NR_GPIOS    = 8,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] GPIO_ID     = DATA_WIDTH'(GPIO_ID_DEFAULT),
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    as_gpio_ctrl_if.slave       bus,
    input  logic [NR_GPIOS-1:0] gpio_i,
    output logic [NR_GPIOS-1:0] gpio_o,
    output logic [NR_GPIOS-1:0] gpio_oe_o,
    output logic                cs_o,
    output logic                irq_o
);

    // Zero-extend a pin-wide value onto the bus.
    function automatic logic [DATA_WIDTH-1:0] zext(input logic [NR_GPIOS-1:0] v);
        return DATA_WIDTH'(v);
    endfunction

    logic [NR_GPIOS-1:0]   r_dir;
    logic [NR_GPIOS-1:0]   r_out;
    logic [NR_GPIOS-1:0]   r_irq_en;
    logic [NR_GPIOS-1:0]   r_stat;
    logic [NR_GPIOS-1:0]   r_rise;
    logic [NR_GPIOS-1:0]   r_fall;
    logic [NR_GPIOS-1:0]   r_prev;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_cs;
    logic                  r_irq;

    logic [NR_GPIOS-1:0]   w_sync;
    logic [NR_GPIOS-1:0]   w_wd;
    logic [NR_GPIOS-1:0]   w_dir_nxt;
    logic [NR_GPIOS-1:0]   w_out_nxt;
    logic [NR_GPIOS-1:0]   w_irq_en_nxt;
    logic [NR_GPIOS-1:0]   w_rise_nxt;
    logic [NR_GPIOS-1:0]   w_fall_nxt;
    logic [NR_GPIOS-1:0]   w_w1c;
    logic [NR_GPIOS-1:0]   w_edge;
    logic [NR_GPIOS-1:0]   w_stat_nxt;
    logic                  w_out_wr;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_unused_wdata;

    as_gpio_ctrl_sync #(
        .NR_GPIOS    (NR_GPIOS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_async (gpio_i),
        .o_sync  (w_sync)
    );

    // Bits above the pin count carry no meaning and are dropped here.
    assign w_wd           = bus.wdata_i[NR_GPIOS-1:0];
    assign w_unused_wdata = ^bus.wdata_i;

    // Write decode: next values of the RW registers and the W1C mask.
    always_comb begin
        w_dir_nxt    = r_dir;
        w_out_nxt    = r_out;
        w_irq_en_nxt = r_irq_en;
        w_rise_nxt   = r_rise;
        w_fall_nxt   = r_fall;
        w_w1c        = '0;
        w_out_wr     = 1'b0;
        if (bus.we_i) begin
            case (bus.addr_i)
                ADDR_WIDTH'(GPIO_DIR_R):    w_dir_nxt = w_wd;
                ADDR_WIDTH'(GPIO_OUT_R): begin
                    w_out_nxt = w_wd;
                    w_out_wr  = 1'b1;
                end
                ADDR_WIDTH'(GPIO_SET_R): begin
                    w_out_nxt = r_out | w_wd;
                    w_out_wr  = 1'b1;
                end
                ADDR_WIDTH'(GPIO_CLR_R): begin
                    w_out_nxt = r_out & ~w_wd;
                    w_out_wr  = 1'b1;
                end
                ADDR_WIDTH'(GPIO_IRQ_EN_R): w_irq_en_nxt = w_wd;
                ADDR_WIDTH'(GPIO_STAT_R):   w_w1c        = w_wd;
                ADDR_WIDTH'(GPIO_RISE_R):   w_rise_nxt   = w_wd;
                ADDR_WIDTH'(GPIO_FALL_R):   w_fall_nxt   = w_wd;
                default:                    w_out_wr     = 1'b0;
            endcase
        end else begin
            w_out_wr = 1'b0;
        end
    end

    // Edge events are ORed in after the W1C mask so a coincident edge wins.
    always_comb begin
        w_edge     = (w_sync & ~r_prev & r_rise) | (~w_sync & r_prev & r_fall);
        w_stat_nxt = (r_stat & ~w_w1c) | w_edge;
    end

    // Read mux on current (pre-write) register contents; write-only and
    // unmapped indices read zero.
    always_comb begin
        w_rd = '0;
        case (bus.addr_i)
            ADDR_WIDTH'(GPIO_ID_R):     w_rd = GPIO_ID;
            ADDR_WIDTH'(GPIO_DIR_R):    w_rd = zext(r_dir);
            ADDR_WIDTH'(GPIO_OUT_R):    w_rd = zext(r_out);
            ADDR_WIDTH'(GPIO_IN_R):     w_rd = zext(w_sync);
            ADDR_WIDTH'(GPIO_IRQ_EN_R): w_rd = zext(r_irq_en);
            ADDR_WIDTH'(GPIO_STAT_R):   w_rd = zext(r_stat);
            ADDR_WIDTH'(GPIO_RISE_R):   w_rd = zext(r_rise);
            ADDR_WIDTH'(GPIO_FALL_R):   w_rd = zext(r_fall);
            default:                    w_rd = '0;
        endcase
    end

    // Register file, edge history and status update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dir    <= '0;
            r_out    <= '0;
            r_irq_en <= '0;
            r_stat   <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_prev   <= '0;
        end else begin
            r_dir    <= w_dir_nxt;
            r_out    <= w_out_nxt;
            r_irq_en <= w_irq_en_nxt;
            r_stat   <= w_stat_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_prev   <= w_sync;
        end
    end

    // Registered bus response, change strobe and interrupt; rdata holds
    // its last value when no read is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_cs     <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (bus.re_i) begin
                r_rdata <= w_rd;
            end else begin
                r_rdata <= r_rdata;
            end
            r_rvalid <= bus.re_i;
            r_cs     <= w_out_wr;
            r_irq    <= |(r_stat & r_irq_en);
        end
    end

    assign bus.rdata_o  = r_rdata;
    assign bus.rvalid_o = r_rvalid;
    assign gpio_o       = r_out;
    assign gpio_oe_o    = r_dir;
    assign cs_o         = r_cs;
    assign irq_o        = r_irq;

endmodule
